seg7_share_arb: RTL and testbench

//   Shares the 4-digit 7-segment display between two requesters.

---
 rtl/seg7_share_arb.sv | 115 +++++++++++
 tb/tb_seg7_share_arb.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_share_arb.sv
// Two-requester arbiter for the shared 4-digit 7-segment display: round-robin with minimum dwell.
// All outputs registered; 1-cycle grant and data latency; requesters wait (req level) until granted.
module seg7_share_arb #(
    parameter int          DWELL    = 1000000,
    parameter int          DWELL_W  = 20,
    parameter logic [15:0] IDLE_VAL = 16'h0000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [15:0] x_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [DWELL_W-1:0] CNT_MAX = DWELL_W'(DWELL - 1);

    state_t               r_state;
    logic                 r_own;
    logic                 r_last;
    logic [DWELL_W-1:0]   r_cnt;

    logic                 w_expired;
    logic [DWELL_W-1:0]   w_cnt_next;
    logic                 w_any;
    logic                 w_pick;
    logic [15:0]          w_data_pick;
    logic                 w_req_own;
    logic                 w_req_oth;
    logic [15:0]          w_data_own;
    logic                 w_do_grant;
    logic                 w_go_idle;

    assign w_expired  = (r_cnt == CNT_MAX);
    assign w_cnt_next = w_expired ? r_cnt : r_cnt + DWELL_W'(1);
    assign w_any      = req0 | req1;

    // A tie goes to the side that did not own last; a lone request always wins.
    assign w_pick      = (req0 & req1) ? ~r_last : req1;
    assign w_data_pick = w_pick ? data1 : data0;

    assign w_req_own  = r_own ? req1 : req0;
    assign w_req_oth  = r_own ? req0 : req1;
    assign w_data_own = r_own ? data1 : data0;

    // In OWN, last always equals own, so a switch target is exactly the pick result.
    always_comb begin
        w_do_grant = 1'b0;
        w_go_idle  = 1'b0;
        case (r_state)
            S_IDLE: w_do_grant = w_any;
            S_OWN: begin
                w_do_grant = w_expired & w_req_oth;
                w_go_idle  = w_expired & ~w_req_own & ~w_req_oth;
            end
            S_HOLD: begin
                w_do_grant = w_expired & w_any;
                w_go_idle  = w_expired & ~w_any;
            end
            default: w_go_idle = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_IDLE;
            r_own   <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            x_out   <= IDLE_VAL;
        end else if (w_do_grant) begin
            r_state <= S_OWN;
            r_own   <= w_pick;
            r_last  <= w_pick;
            r_cnt   <= '0;
            gnt0    <= ~w_pick;
            gnt1    <= w_pick;
            busy    <= 1'b1;
            x_out   <= w_data_pick;
        end else if (w_go_idle) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            x_out   <= IDLE_VAL;
        end else if (r_state == S_OWN) begin
            r_cnt <= w_cnt_next;
            if (w_req_own) begin
                x_out <= w_data_own;
            end else begin
                // Owner released early: keep the display frozen until dwell runs out.
                r_state <= S_HOLD;
                gnt0    <= 1'b0;
                gnt1    <= 1'b0;
            end
        end else if (r_state == S_HOLD) begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: tb/tb_seg7_share_arb.sv
// Scoreboard bench for seg7_share_arb with DWELL=4: directed vectors, expected outputs queued per edge.
module tb_seg7_share_arb;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req0 = 1'b0;
    logic [15:0] data0 = 16'h0000;
    logic        req1 = 1'b0;
    logic [15:0] data1 = 16'h0000;
    logic        gnt0;
    logic        gnt1;
    logic [15:0] x_out;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        g0;
        logic        g1;
        logic        busy;
        logic [15:0] x;
        logic        hold;
    } exp_t;

    exp_t exp_q[$];

    seg7_share_arb #(
        .DWELL   (4),
        .DWELL_W (3),
        .IDLE_VAL(16'h0000)
    ) dut (
        .clk  (clk),
        .clr  (clr),
        .req0 (req0),
        .data0(data0),
        .req1 (req1),
        .data1(data1),
        .gnt0 (gnt0),
        .gnt1 (gnt1),
        .x_out(x_out),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive inputs at the falling edge; the expected outputs after the next rising edge are queued.
    task automatic cyc(input logic r0, input logic [15:0] d0, input logic r1, input logic [15:0] d1,
                       input logic eg0, input logic eg1, input logic eb, input logic [15:0] ex,
                       input logic eh);
        exp_t e;
        @(negedge clk);
        req0  = r0;
        data0 = d0;
        req1  = r1;
        data1 = d1;
        e.g0   = eg0;
        e.g1   = eg1;
        e.busy = eb;
        e.x    = ex;
        e.hold = eh;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("gnt_mutex", {31'd0, gnt0 & gnt1}, 32'd0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs{g0,g1,busy,x}", {13'd0, gnt0, gnt1, busy, x_out},
                      {13'd0, e.g0, e.g1, e.busy, e.x});
                if (!e.hold)
                    check("busy_vs_gnt", {31'd0, busy}, {31'd0, gnt0 | gnt1});
            end
        end
    end

    initial begin : watchdog
        #50000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stimulus
        #2;
        check("reset_outputs", {13'd0, gnt0, gnt1, busy, x_out}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        // Single requester: 1-cycle grant latency, then data follows with 1-cycle latency.
        cyc(1, 16'h1234, 0, 16'h0000, 1, 0, 1, 16'h1234, 0);
        cyc(1, 16'hABCD, 0, 16'h0000, 1, 0, 1, 16'hABCD, 0);
        cyc(1, 16'hABCD, 0, 16'h0000, 1, 0, 1, 16'hABCD, 0);
        cyc(1, 16'h4321, 0, 16'h0000, 1, 0, 1, 16'h4321, 0);
        cyc(1, 16'h4321, 0, 16'h0000, 1, 0, 1, 16'h4321, 0);

        // Asynchronous clear in the middle of OWN.
        @(negedge clk);
        req0 = 1'b0;
        #1 clr = 1'b1;
        #1;
        check("async_clr", {13'd0, gnt0, gnt1, busy, x_out}, 32'd0);
        clr = 1'b0;

        // Both request from reset: req0 first, alternate every 4 cycles, no gap.
        cyc(1, 16'h1111, 1, 16'h2222, 1, 0, 1, 16'h1111, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 1, 0, 1, 16'h1111, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 1, 0, 1, 16'h1111, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 1, 0, 1, 16'h1111, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 0, 1, 1, 16'h2222, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 0, 1, 1, 16'h2222, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 0, 1, 1, 16'h2222, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 0, 1, 1, 16'h2222, 0);
        cyc(1, 16'h1111, 1, 16'h2222, 1, 0, 1, 16'h1111, 0);
        // Both drop before expiry: HOLD, then IDLE.
        cyc(0, 16'h9999, 0, 16'h8888, 0, 0, 1, 16'h1111, 1);
        cyc(0, 16'h9999, 0, 16'h8888, 0, 0, 1, 16'h1111, 1);
        cyc(0, 16'h9999, 0, 16'h8888, 0, 0, 1, 16'h1111, 1);
        cyc(0, 16'h9999, 0, 16'h8888, 0, 0, 0, 16'h0000, 0);

        // req0 drops one cycle after grant: x_out frozen through HOLD despite data changes.
        cyc(1, 16'h5A5A, 0, 16'h0000, 1, 0, 1, 16'h5A5A, 0);
        cyc(0, 16'hFFFF, 0, 16'h0000, 0, 0, 1, 16'h5A5A, 1);
        cyc(0, 16'hFFFF, 0, 16'h0000, 0, 0, 1, 16'h5A5A, 1);
        cyc(0, 16'hFFFF, 0, 16'h0000, 0, 0, 1, 16'h5A5A, 1);
        cyc(0, 16'hFFFF, 0, 16'h0000, 0, 0, 0, 16'h0000, 0);

        // HOLD owned by 0, both rise early: no grant until expiry, then req1 wins.
        cyc(1, 16'h0A0A, 0, 16'h0B0B, 1, 0, 1, 16'h0A0A, 0);
        cyc(0, 16'h0A0A, 0, 16'h0B0B, 0, 0, 1, 16'h0A0A, 1);
        cyc(1, 16'h0A0A, 1, 16'h0B0B, 0, 0, 1, 16'h0A0A, 1);
        cyc(1, 16'h0A0A, 1, 16'h0B0B, 0, 0, 1, 16'h0A0A, 1);
        cyc(0, 16'h0A0A, 1, 16'h0B0B, 0, 1, 1, 16'h0B0B, 0);
        // Owner 1 keeps req through dwell, then both drop once expired: straight to IDLE.
        cyc(0, 16'h0A0A, 1, 16'h0C0C, 0, 1, 1, 16'h0C0C, 0);
        cyc(0, 16'h0A0A, 1, 16'h0C0C, 0, 1, 1, 16'h0C0C, 0);
        cyc(0, 16'h0A0A, 1, 16'h0C0C, 0, 1, 1, 16'h0C0C, 0);
        cyc(0, 16'h0A0A, 0, 16'h0C0C, 0, 0, 0, 16'h0000, 0);

        @(negedge clk);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
